id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- Pipeline register between Decode (register file read, immediate sign-extension) and Execute in the 5-stage MIPS pipeline.
- Captures decoded control, register operands, the 32-bit sign-extended immediate and register specifiers on each clock edge.
- Supports hold (stall) and bubble insertion (flush).
- Keeps a valid bit and a saturating bubble counter for debug and performance readout.

Parameters:
- DW, 32, operand and immediate data width.
- RW, 5, register specifier width.
- CNTW, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all E-stage contents this cycle.
- flush  in  1  load a bubble (NOP) into the E stage this cycle.
- valid_d  in  1  Decode holds a real instruction.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD  in  1 each  decoded control bits.
- ALUControlD  in  3  ALU operation.
- RD1D, RD2D  in  DW  register file read data.
- SignImmD  in  DW  sign-extended immediate from the Decode extender.
- RsD, RtD, RdD  in  RW  register specifiers.
- valid_e  out  1  E stage holds a real instruction.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE  out  1 each  registered control bits.
- ALUControlE  out  3  registered ALU operation.
- RD1E, RD2E, SignImmE  out  DW  registered operands.
- RsE, RtE, RdE  out  RW  registered specifiers.
- WriteRegE  out  RW  combinational from registered values: RdE if RegDstE=1, else RtE.
- bubble_cnt  out  CNTW  count of bubbles inserted since reset; saturates.

Behaviour:
- All outputs are registered except WriteRegE.
- Reset (synchronous, highest priority):
  - All control outputs and valid_e = 0.
  - ALUControlE = 3'b000.
  - Data and specifier outputs = 0.
  - bubble_cnt = 0.
  - Reset asserted mid-stall or mid-flush overrides both.
- Priority below reset: flush > stall > normal load.
- Normal load (stall=0, flush=0): every E output takes its D input on the edge; valid_e <= valid_d. Latency is one cycle.
- Stall (stall=1, flush=0): all E registers keep their values. bubble_cnt is unchanged.
- Flush (flush=1, regardless of stall):
  - valid_e, RegWriteE, MemtoRegE, MemWriteE and BranchE <= 0.
  - ALUControlE, ALUSrcE and RegDstE <= 0.
  - Data and specifier registers <= 0, so a bubble cannot create a false forwarding match on RsE/RtE.
- Bubble counter:
  - Increments by 1 on every edge where flush=1, or where stall=0 and valid_d=0.
  - Holds at 2^CNTW-1 (saturates, no wrap).
  - A reset edge clears it and overrides any increment.
- Invalid-instruction sanitising: on a normal load with valid_d=0, the state-changing controls (RegWriteE, MemWriteE, BranchE) load 0 whatever the D inputs are. The other fields load normally.
- SignImmE is stored bit-exact: no re-extension or truncation. Upper 16 bits equal SignImmD[15] replicated, as produced upstream.
- No combinational path from any D input to any E output. WriteRegE depends only on registered values.

Test Plan:
- Reset then load: reset=1 for 2 cycles → all outputs 0 and bubble_cnt=0. Then drive valid_d=1, RegWriteD=1, ALUControlD=3'b010, RD1D=32'h0000_0005, SignImmD=32'hFFFF_FFFC, RtD=5'd8, RegDstD=0 → one cycle later: RegWriteE=1, ALUControlE=3'b010, RD1E=5, SignImmE=32'hFFFF_FFFC, WriteRegE=8, valid_e=1.
- Stall hold: load SignImmD=32'h0000_7FFF, then stall=1 for 3 cycles while SignImmD=32'h1234_5678 → SignImmE stays 32'h0000_7FFF for all 3 cycles, bubble_cnt unchanged. Release stall → SignImmE=32'h1234_5678 on the next edge.
- Flush with stall: flush=1 and stall=1 together, with RegWriteD=1, MemWriteD=1, RsD=5'd3 → next cycle valid_e=0, RegWriteE=0, MemWriteE=0, RsE=0; bubble_cnt increments by 1.
- Invalid sanitising: valid_d=0, RegWriteD=1, MemWriteD=1, BranchD=1, RD2D=32'hDEAD_BEEF, stall=0 → RegWriteE=MemWriteE=BranchE=0, RD2E=32'hDEAD_BEEF, bubble_cnt+1.
- Saturation: CNTW=4, flush=1 for 20 cycles → bubble_cnt reaches 15 and stays at 15. Reset asserted with flush=1 → bubble_cnt=0.
- WriteReg mux: RegDstD=1, RdD=5'd17, RtD=5'd9 → WriteRegE=17. Next load with RegDstD=0 → WriteRegE=9.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures the decoded controls, register operands, sign-extended immediate
// and register specifiers from Decode on every rising edge. It supports
// holding (stall) and bubble insertion (flush) and keeps a valid bit plus a
// saturating bubble counter for debug and performance readout.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   stall, flush            hold E stage / load a bubble (flush wins)
//   valid_d                 Decode holds a real instruction
//   *D                      decoded controls, operands and specifiers
//   valid_e, *E             registered E-stage copies
//   WriteRegE               RdE when RegDstE=1, else RtE (from registered values only)
//   bubble_cnt              bubbles inserted since reset, saturating
module id_ex_register #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_d,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            MemWriteD,
  input  logic            ALUSrcD,
  input  logic            RegDstD,
  input  logic            BranchD,
  input  logic [2:0]      ALUControlD,
  input  logic [DW-1:0]   RD1D,
  input  logic [DW-1:0]   RD2D,
  input  logic [DW-1:0]   SignImmD,
  input  logic [RW-1:0]   RsD,
  input  logic [RW-1:0]   RtD,
  input  logic [RW-1:0]   RdD,
  output logic            valid_e,
  output logic            RegWriteE,
  output logic            MemtoRegE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic            RegDstE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [DW-1:0]   RD1E,
  output logic [DW-1:0]   RD2E,
  output logic [DW-1:0]   SignImmE,
  output logic [RW-1:0]   RsE,
  output logic [RW-1:0]   RtE,
  output logic [RW-1:0]   RdE,
  output logic [RW-1:0]   WriteRegE,
  output logic [CNTW-1:0] bubble_cnt
);

  logic            valid_e_q,   valid_e_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            mem_write_q, mem_write_d;
  logic            alu_src_q,   alu_src_d;
  logic            reg_dst_q,   reg_dst_d;
  logic            branch_q,    branch_d;
  logic [2:0]      alu_ctrl_q,  alu_ctrl_d;
  logic [DW-1:0]   rd1_q,       rd1_d;
  logic [DW-1:0]   rd2_q,       rd2_d;
  logic [DW-1:0]   sign_imm_q,  sign_imm_d;
  logic [RW-1:0]   rs_q,        rs_d;
  logic [RW-1:0]   rt_q,        rt_d;
  logic [RW-1:0]   rd_q,        rd_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;
  logic            bubble_inc;

  // A bubble enters E either by flush or by a normal load of an invalid slot.
  assign bubble_inc = flush | (~stall & ~valid_d);

  always_comb begin
    valid_e_d    = valid_e_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    alu_src_d    = alu_src_q;
    reg_dst_d    = reg_dst_q;
    branch_d     = branch_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    sign_imm_d   = sign_imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      // Specifiers are zeroed too so a bubble never matches a forwarding compare.
      valid_e_d    = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      reg_dst_d    = 1'b0;
      branch_d     = 1'b0;
      alu_ctrl_d   = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      sign_imm_d   = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
    end else if (!stall) begin
      valid_e_d    = valid_d;
      // State-changing controls are masked for an invalid slot.
      reg_write_d  = RegWriteD & valid_d;
      mem_write_d  = MemWriteD & valid_d;
      branch_d     = BranchD   & valid_d;
      mem_to_reg_d = MemtoRegD;
      alu_src_d    = ALUSrcD;
      reg_dst_d    = RegDstD;
      alu_ctrl_d   = ALUControlD;
      rd1_d        = RD1D;
      rd2_d        = RD2D;
      sign_imm_d   = SignImmD;
      rs_d         = RsD;
      rt_d         = RtD;
      rd_d         = RdD;
    end

    if (bubble_inc && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_e_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      branch_q     <= 1'b0;
      alu_ctrl_q   <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      sign_imm_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_e_q    <= valid_e_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      branch_q     <= branch_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      sign_imm_q   <= sign_imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_e     = valid_e_q;
  assign RegWriteE   = reg_write_q;
  assign MemtoRegE   = mem_to_reg_q;
  assign MemWriteE   = mem_write_q;
  assign ALUSrcE     = alu_src_q;
  assign RegDstE     = reg_dst_q;
  assign BranchE     = branch_q;
  assign ALUControlE = alu_ctrl_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign SignImmE    = sign_imm_q;
  assign RsE         = rs_q;
  assign RtE         = rt_q;
  assign RdE         = rd_q;
  assign WriteRegE   = reg_dst_q ? rd_q : rt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Testbench for id_ex_register: a default-width instance and a CNTW=4
// instance share all stimulus; both are checked against a field-level model.
module tb_id_ex_register;

  localparam int VW = 10 + 3 * 32 + 4 * 5;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_d;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;

  logic        valid_e, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;
  logic [15:0] bubble_cnt;

  logic        s_valid_e, s_RegWriteE, s_MemtoRegE, s_MemWriteE, s_ALUSrcE, s_RegDstE, s_BranchE;
  logic [2:0]  s_ALUControlE;
  logic [31:0] s_RD1E, s_RD2E, s_SignImmE;
  logic [4:0]  s_RsE, s_RtE, s_RdE, s_WriteRegE;
  logic [3:0]  s_bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_register u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_d(valid_d),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .valid_e(valid_e), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .WriteRegE(WriteRegE), .bubble_cnt(bubble_cnt)
  );

  id_ex_register #(.CNTW(4)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_d(valid_d),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .valid_e(s_valid_e), .RegWriteE(s_RegWriteE), .MemtoRegE(s_MemtoRegE),
    .MemWriteE(s_MemWriteE), .ALUSrcE(s_ALUSrcE), .RegDstE(s_RegDstE), .BranchE(s_BranchE),
    .ALUControlE(s_ALUControlE), .RD1E(s_RD1E), .RD2E(s_RD2E), .SignImmE(s_SignImmE),
    .RsE(s_RsE), .RtE(s_RtE), .RdE(s_RdE), .WriteRegE(s_WriteRegE), .bubble_cnt(s_bubble_cnt)
  );

  logic [VW-1:0] dut_vec, sat_vec;
  assign dut_vec = {valid_e, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE,
                    ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE};
  assign sat_vec = {s_valid_e, s_RegWriteE, s_MemtoRegE, s_MemWriteE, s_ALUSrcE, s_RegDstE,
                    s_BranchE, s_ALUControlE, s_RD1E, s_RD2E, s_SignImmE, s_RsE, s_RtE, s_RdE,
                    s_WriteRegE};

  // Reference model: the E-stage contents as named fields plus integer counters.
  typedef struct {
    logic        v, rw, mtr, mw, as, rdst, br;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    int          cnt, cnt4;
  } model_t;
  model_t m;

  function automatic logic [VW-1:0] model_vec();
    return {m.v, m.rw, m.mtr, m.mw, m.as, m.rdst, m.br, m.alu, m.rd1, m.rd2, m.imm,
            m.rs, m.rt, m.rd, (m.rdst ? m.rd : m.rt)};
  endfunction

  function automatic void clear_fields();
    m.v = 0; m.rw = 0; m.mtr = 0; m.mw = 0; m.as = 0; m.rdst = 0; m.br = 0;
    m.alu = 0; m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.rs = 0; m.rt = 0; m.rd = 0;
  endfunction

  // One clock edge: advance the model from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      clear_fields();
      m.cnt = 0;
      m.cnt4 = 0;
    end else begin
      if (flush || !stall) begin
        if (flush) clear_fields();
        else begin
          m.v = valid_d; m.mtr = MemtoRegD; m.as = ALUSrcD; m.rdst = RegDstD;
          m.alu = ALUControlD; m.rd1 = RD1D; m.rd2 = RD2D; m.imm = SignImmD;
          m.rs = RsD; m.rt = RtD; m.rd = RdD;
          m.rw = valid_d ? RegWriteD : 1'b0;
          m.mw = valid_d ? MemWriteD : 1'b0;
          m.br = valid_d ? BranchD : 1'b0;
        end
        if (flush || !valid_d) begin
          if (m.cnt < 65535) m.cnt++;
          if (m.cnt4 < 15) m.cnt4++;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; valid_d = 0;
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; RegDstD = 0; BranchD = 0;
    ALUControlD = 0; RD1D = 0; RD2D = 0; SignImmD = 0; RsD = 0; RtD = 0; RdD = 0;
  endtask

  task automatic rand_data();
    valid_d = 1'($urandom); RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom);
    MemWriteD = 1'($urandom); ALUSrcD = 1'($urandom); RegDstD = 1'($urandom);
    BranchD = 1'($urandom); ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; SignImmD = 32'($signed(16'($urandom)));
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic test_reset();
    rand_data();
    reset = 1; flush = 1'($urandom); stall = 1'($urandom);
    tick();
    tick();
    checks++;
    if (dut_vec !== model_vec() || dut_vec !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec, model_vec());
    end
    checks++;
    if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_bubble_cnt: got %0d/%0d expected 0/0", bubble_cnt, s_bubble_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_load();
    valid_d = 1; RegWriteD = 1; ALUControlD = 3'b010; RD1D = 32'h0000_0005;
    SignImmD = 32'hFFFF_FFFC; RtD = 5'd8; RegDstD = 0;
    tick();
    checks++;
    if (RegWriteE !== 1'b1 || ALUControlE !== 3'b010 || RD1E !== 32'd5 ||
        SignImmE !== 32'hFFFF_FFFC || WriteRegE !== 5'd8 || valid_e !== 1'b1) begin
      failures++;
      $display("FAIL load_basic: got rw=%b alu=%b rd1=%h imm=%h wr=%0d v=%b expected 1 010 5 fffffffc 8 1",
               RegWriteE, ALUControlE, RD1E, SignImmE, WriteRegE, valid_e);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL load_vec: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_stall_hold();
    logic [15:0] cnt_before;
    clear_inputs();
    valid_d = 1; SignImmD = 32'h0000_7FFF;
    tick();
    cnt_before = bubble_cnt;
    stall = 1; SignImmD = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (SignImmE !== 32'h0000_7FFF || bubble_cnt !== cnt_before) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got imm=%h cnt=%0d expected imm=00007fff cnt=%0d",
                 i, SignImmE, bubble_cnt, cnt_before);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (SignImmE !== 32'h1234_5678 || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL stall_release: got imm=%h expected 12345678 (vec %h vs %h)",
               SignImmE, dut_vec, model_vec());
    end
  endtask

  task automatic test_flush_stall();
    logic [15:0] cnt_before;
    cnt_before = bubble_cnt;
    rand_data();
    valid_d = 1; RegWriteD = 1; MemWriteD = 1; RsD = 5'd3;
    flush = 1; stall = 1;
    tick();
    checks++;
    if (valid_e !== 1'b0 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || RsE !== 5'd0 ||
        bubble_cnt !== cnt_before + 16'd1) begin
      failures++;
      $display("FAIL flush_stall: got v=%b rw=%b mw=%b rs=%0d cnt=%0d expected 0 0 0 0 cnt=%0d",
               valid_e, RegWriteE, MemWriteE, RsE, bubble_cnt, cnt_before + 16'd1);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL flush_vec: got %h expected %h", dut_vec, model_vec());
    end
    clear_inputs();
  endtask

  task automatic test_invalid();
    logic [15:0] cnt_before;
    cnt_before = bubble_cnt;
    rand_data();
    valid_d = 0; RegWriteD = 1; MemWriteD = 1; BranchD = 1; RD2D = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || BranchE !== 1'b0 ||
        RD2E !== 32'hDEAD_BEEF || bubble_cnt !== cnt_before + 16'd1) begin
      failures++;
      $display("FAIL invalid_sanitise: got rw=%b mw=%b br=%b rd2=%h cnt=%0d expected 0 0 0 deadbeef cnt=%0d",
               RegWriteE, MemWriteE, BranchE, RD2E, bubble_cnt, cnt_before + 16'd1);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL invalid_vec: got %h expected %h", dut_vec, model_vec());
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    reset = 1;
    tick();
    reset = 0; flush = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (s_bubble_cnt !== 4'((i > 15) ? 15 : i) || bubble_cnt !== 16'(i)) begin
        failures++;
        $display("FAIL saturate[%0d]: got %0d/%0d expected %0d/%0d",
                 i, s_bubble_cnt, bubble_cnt, (i > 15) ? 15 : i, i);
      end
    end
    reset = 1;
    tick();
    checks++;
    if (s_bubble_cnt !== 4'd0 || bubble_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_over_flush: got %0d/%0d expected 0/0", s_bubble_cnt, bubble_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_writereg_mux();
    valid_d = 1; RegDstD = 1; RdD = 5'd17; RtD = 5'd9;
    tick();
    checks++;
    if (WriteRegE !== 5'd17) begin
      failures++;
      $display("FAIL writereg_rd: got %0d expected 17", WriteRegE);
    end
    RegDstD = 0;
    tick();
    checks++;
    if (WriteRegE !== 5'd9) begin
      failures++;
      $display("FAIL writereg_rt: got %0d expected 9", WriteRegE);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_data();
      reset = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (dut_vec !== model_vec() || sat_vec !== model_vec() ||
          bubble_cnt !== 16'(m.cnt) || s_bubble_cnt !== 4'(m.cnt4)) begin
        failures++;
        $display("FAIL random[%0d]: got %h cnt=%0d/%0d expected %h cnt=%0d/%0d",
                 i, dut_vec, bubble_cnt, s_bubble_cnt, model_vec(), m.cnt, m.cnt4);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    clear_fields();
    m.cnt = 0;
    m.cnt4 = 0;
    test_reset();
    test_load();
    test_stall_hold();
    test_flush_stall();
    test_invalid();
    test_saturation();
    test_writereg_mux();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
